wptr_ctrl: RTL

Parametrised write-side pointer controller for the asynchronous FIFO, running entirely in the write clock domain. It keeps binary and Gray write pointers and decodes full from the synchronised Gray read pointer. Beyond basic full detection, it provides:
- registered fill level;
- programmable almost-full flag;
- write-accept acknowledge;
- overflow pulse and sticky overflow status with clear.

---
 rtl/wptr_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wptr_ctrl.sv
// wptr_ctrl
// ---------------------------------------------------------------------------
// Write-side pointer controller for an asynchronous FIFO. Everything runs in
// the write clock domain. The block keeps the binary write pointer (used to
// address the RAM) and its Gray-coded copy (handed to the read-side
// synchroniser). It decodes full from the synchronised Gray read pointer, and
// also provides:
//   - a registered fill level
//   - a programmable almost-full flag
//   - a write acknowledge
//   - overflow reporting, as a one-cycle pulse plus a clearable sticky bit
//
// Parameters
//   PTR_WIDTH  address bits, FIFO depth D = 2**PTR_WIDTH (>= 2)
//   AF_LEVEL   level at or above which almost_full asserts (1..D)
//
// Ports
//   wclk         in   write clock, rising edge
//   wrst_n       in   asynchronous active-low reset
//   w_en         in   write request
//   g_rptr_sync  in   Gray read pointer, already synchronised into wclk
//   ovf_clr      in   clears ovf_sticky (a simultaneous overflow wins)
//   b_wptr       out  binary write pointer, low PTR_WIDTH bits address the RAM
//   g_wptr       out  Gray write pointer
//   full         out  FIFO full
//   almost_full  out  wlevel >= AF_LEVEL
//   wlevel       out  occupancy seen from the write side, 0..D
//   wr_ack       out  pulse: a write was accepted on the previous edge
//   wr_ovf       out  pulse: a write was attempted while full
//   ovf_sticky   out  latched overflow indication
// ---------------------------------------------------------------------------
module wptr_ctrl #(
  parameter int PTR_WIDTH = 3,
  parameter int AF_LEVEL  = (1 << PTR_WIDTH) - 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr_sync,
  input  logic                 ovf_clr,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wlevel,
  output logic                 wr_ack,
  output logic                 wr_ovf,
  output logic                 ovf_sticky
);

  localparam int W = PTR_WIDTH + 1;
  localparam logic [W-1:0] AF_THRESH = W'(AF_LEVEL);

  logic         push;
  logic         ovf_attempt;
  logic [W-1:0] b_next;
  logic [W-1:0] g_next;
  logic [W-1:0] rbin;
  logic [W-1:0] lvl_next;
  logic [W-1:0] full_pattern;
  logic         full_next;
  logic         almost_full_next;

  // The registered full gates the request. A write seen while full is dropped
  // and reported as an overflow. This same push is the RAM write enable.
  assign push        = w_en & ~full;
  assign ovf_attempt = w_en & full;

  // Next pointers. Binary arithmetic wraps naturally at 2**W, and the Gray
  // copy is derived from the binary value so that it only ever steps by one
  // bit.
  assign b_next = b_wptr + {{PTR_WIDTH{1'b0}}, push};
  assign g_next = b_next ^ (b_next >> 1);

  // Gray-to-binary of the read pointer: each binary bit is the XOR of all
  // Gray bits at or above it, evaluated from the MSB down.
  always_comb begin
    rbin        = '0;
    rbin[W-1]   = g_rptr_sync[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ g_rptr_sync[i];
    end
  end

  // Occupancy after this edge. Modulo subtraction keeps it correct across
  // pointer wrap. For legal read pointers it is always in 0..D.
  assign lvl_next = b_next - rbin;

  // Full when the write pointer is exactly one lap ahead. In Gray code that
  // means the two MSBs are inverted and the remaining bits match.
  assign full_pattern = {~g_rptr_sync[W-1:W-2], g_rptr_sync[W-3:0]};
  assign full_next    = (g_next == full_pattern);

  assign almost_full_next = (lvl_next >= AF_THRESH);

  // All outputs are registered. Reset clears every output immediately, and
  // any pointer values in flight are discarded.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      wr_ack      <= 1'b0;
      wr_ovf      <= 1'b0;
      ovf_sticky  <= 1'b0;
    end else begin
      b_wptr      <= b_next;
      g_wptr      <= g_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      wlevel      <= lvl_next;
      wr_ack      <= push;
      wr_ovf      <= ovf_attempt;
      // A new overflow takes priority over a clear in the same cycle, so an
      // event is never lost.
      if (ovf_attempt) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule
